// File: rtl/lock_detect_pkg.sv
// Shared state encoding and default timing parameters for the PLL lock detector.
package lock_detect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_ACQ   = 2'd2,
        ST_LOCK  = 2'd3
    } state_t;

    localparam int DEF_EXP_PERIOD = 20;
    localparam int DEF_TOL        = 1;
    localparam int DEF_LOCK_CNT   = 8;
    localparam int DEF_TIMEOUT    = 64;
    localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for the monitored clock followed by a registered rising-edge detect.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic sync_3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            sync_3 <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_1 <= d;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
            rise   <= sync_2 & ~sync_3;
        end
    end

endmodule

// File: rtl/lock_detect.sv
// PLL lock detector: measures mon_clk period in clk cycles and declares lock after
// LOCK_CNT consecutive in-tolerance periods; loses lock on mismatch or missing edges.
//
// state    | meaning
// ST_IDLE  | disabled, counters cleared
// ST_FIRST | waiting for the first edge to start a measurement
// ST_ACQ   | measuring, counting consecutive in-tolerance periods
// ST_LOCK  | locked, LOCKED asserted
module lock_detect
    import lock_detect_pkg::*;
#(
    parameter int EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int TOL        = DEF_TOL,
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mon_clk,
    input  logic             en,
    output logic             LOCKED,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             lock_lost
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]   TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [MATCH_W-1:0] LOCK_V    = MATCH_W'(LOCK_CNT);
    // Lower bound clamps at zero so a tolerance wider than the period cannot wrap.
    localparam logic [CNT_W:0] TOL_LO = (CNT_W+1)'((EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0);
    localparam logic [CNT_W:0] TOL_HI = (CNT_W+1)'(EXP_PERIOD + TOL);

    logic               rise;
    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [MATCH_W-1:0] match, match_nx;
    logic [CNT_W:0]     meas;
    logic               in_tol;
    logic               timeout_hit;
    logic               measure;
    logic               lost_nx;

    edge_sync u_edge_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (mon_clk),
        .rise (rise)
    );

    assign meas        = {1'b0, cnt};
    assign in_tol      = (meas >= TOL_LO) && (meas <= TOL_HI);
    assign timeout_hit = (cnt == TIMEOUT_V);

    always_comb begin
        state_nx = state;
        match_nx = match;
        measure  = 1'b0;
        lost_nx  = 1'b0;
        cnt_nx   = rise ? CNT_ONE : ((cnt == CNT_MAX) ? cnt : cnt + 1'b1);
        if (!en) begin
            state_nx = ST_IDLE;
            match_nx = '0;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_nx = ST_FIRST;
                    cnt_nx   = '0;
                end
                ST_FIRST: begin
                    if (rise) begin
                        state_nx = ST_ACQ;
                        match_nx = '0;
                    end
                end
                ST_ACQ: begin
                    if (rise) begin
                        measure = 1'b1;
                        if (in_tol) begin
                            match_nx = match + 1'b1;
                            if (match_nx == LOCK_V) state_nx = ST_LOCK;
                        end else begin
                            match_nx = '0;
                        end
                    end else if (timeout_hit) begin
                        state_nx = ST_FIRST;
                        match_nx = '0;
                    end
                end
                ST_LOCK: begin
                    if (rise) begin
                        measure = 1'b1;
                        if (!in_tol) begin
                            state_nx = ST_ACQ;
                            match_nx = '0;
                            lost_nx  = 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state_nx = ST_FIRST;
                        match_nx = '0;
                        lost_nx  = 1'b1;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            match        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            LOCKED       <= 1'b0;
            lock_lost    <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            match        <= match_nx;
            period_valid <= measure;
            LOCKED       <= (state_nx == ST_LOCK);
            lock_lost    <= lost_nx;
            if (measure) period <= cnt;
        end
    end

endmodule

// File: tb/tb_lock_detect.sv
// Self-checking bench for lock_detect: directed and randomized mon_clk period sequences
// compared against a period-level lock model.
module tb_lock_detect;
    import lock_detect_pkg::*;

    typedef int iq_t[$];
    typedef logic [18:0] ev_t;   // {period_valid, LOCKED, lock_lost, period}
    typedef ev_t evq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        mon_clk;
    logic        en;
    logic        locked;
    logic [15:0] period;
    logic        period_valid;
    logic        lock_lost;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    ev_t got_q[$];
    int  got_t[$];

    lock_detect dut (
        .clk          (clk),
        .rst          (rst),
        .mon_clk      (mon_clk),
        .en           (en),
        .LOCKED       (locked),
        .period       (period),
        .period_valid (period_valid),
        .lock_lost    (lock_lost)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (period_valid || lock_lost) begin
            got_q.push_back({period_valid, locked, lock_lost, period});
            got_t.push_back(cyc);
        end
    end

    // Reference: one event per measured period, lock after LOCK_CNT consecutive good periods.
    function automatic evq_t model(iq_t q);
        evq_t e;
        int   m = 0;
        bit   lk = 0;
        bit   lost;
        bit   ok;
        foreach (q[i]) begin
            ok   = (q[i] >= DEF_EXP_PERIOD - DEF_TOL) && (q[i] <= DEF_EXP_PERIOD + DEF_TOL);
            lost = 0;
            if (lk) begin
                if (!ok) begin
                    lk = 0; m = 0; lost = 1;
                end
            end else if (ok) begin
                m++;
                if (m == DEF_LOCK_CNT) lk = 1;
            end else begin
                m = 0;
            end
            e.push_back({1'b1, lk, lost, 16'(q[i])});
        end
        return e;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start();
        rst = 1'b0; en = 1'b0; mon_clk = 1'b0;
        cycles(2);
        rst = 1'b1;
        cycles(1);
        en = 1'b1;
        cycles(2);
        got_q.delete();
        got_t.delete();
    endtask

    // One rising edge per listed period plus a closing edge.
    task automatic drive(input iq_t q);
        mon_clk = 1'b0;
        cycles(3);
        foreach (q[i]) begin
            mon_clk = 1'b1;
            cycles(q[i] / 2);
            mon_clk = 1'b0;
            cycles(q[i] - q[i] / 2);
        end
        mon_clk = 1'b1;
        cycles(2);
        mon_clk = 1'b0;
        cycles(8);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; mon_clk = 1'b0;
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if ({locked, period, period_valid, lock_lost} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", {locked, period, period_valid, lock_lost});
        end
        for (int i = 0; i < 6; i++) begin
            mon_clk = ~mon_clk;
            cycles(2);
        end
        rst = 1'b1;
        cycles(10);
        n_cmp++;
        if ({locked, period, period_valid, lock_lost} !== 19'd0 || got_q.size() != 0) begin
            n_bad++;
            $display("FAIL idle_disabled: got outputs %h events %0d want 0/0",
                     {locked, period, period_valid, lock_lost}, got_q.size());
        end
    endtask

    task automatic test_lock();
        iq_t  q;
        evq_t exp_q;
        start();
        repeat (8) q.push_back(20);
        drive(q);
        exp_q = model(q);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL lock_count: got %0d events want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL lock_event[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_mismatch_relock();
        iq_t  q;
        evq_t exp_q;
        start();
        repeat (8) q.push_back(20);
        q.push_back(24);
        repeat (8) q.push_back(20);
        drive(q);
        exp_q = model(q);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL mismatch_count: got %0d events want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL mismatch_event[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_tolerance_edges();
        iq_t  q;
        evq_t exp_q;
        for (int pass = 0; pass < 2; pass++) begin
            start();
            q.delete();
            for (int i = 0; i < 10; i++)
                q.push_back(pass == 0 ? ((i % 2) ? 21 : 19) : ((i % 2) ? 22 : 18));
            drive(q);
            exp_q = model(q);
            n_cmp++;
            if (got_q.size() != exp_q.size()) begin
                n_bad++;
                $display("FAIL tol_count[%0d]: got %0d events want %0d", pass, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL tol_event[%0d][%0d]: got %h want %h", pass, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        iq_t  q;
        evq_t exp_q;
        start();
        repeat (8) q.push_back(20);
        drive(q);
        cycles(70);
        n_cmp++;
        if (got_q.size() != 9) begin
            n_bad++;
            $display("FAIL timeout_count: got %0d events want 9", got_q.size());
        end else begin
            n_cmp++;
            if (got_q[8] !== {1'b0, 1'b0, 1'b1, 16'd20}) begin
                n_bad++;
                $display("FAIL timeout_event: got %h want %h", got_q[8], {1'b0, 1'b0, 1'b1, 16'd20});
            end
            n_cmp++;
            if (got_t[8] - got_t[7] != DEF_TIMEOUT) begin
                n_bad++;
                $display("FAIL timeout_delay: got %0d want %0d", got_t[8] - got_t[7], DEF_TIMEOUT);
            end
        end
        // After a timeout the detector restarts: first edge only opens a measurement.
        drive(q);
        exp_q = model(q);
        n_cmp++;
        if (got_q.size() != 9 + exp_q.size()) begin
            n_bad++;
            $display("FAIL restart_count: got %0d events want %0d", got_q.size(), 9 + exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && 9 + i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[9 + i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL restart_event[%0d]: got %h want %h", i, got_q[9 + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_coincident_timeout();
        iq_t  q;
        evq_t exp_q;
        start();
        q = '{20, 20, 20, 64, 20, 20};
        drive(q);
        exp_q = model(q);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL coincide_count: got %0d events want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL coincide_event[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_enable_off();
        iq_t q;
        start();
        repeat (8) q.push_back(20);
        drive(q);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL en_locked_before: got %b want 1", locked);
        end
        en = 1'b0;
        cycles(1);
        n_cmp++;
        if ({locked, lock_lost, period} !== {1'b0, 1'b0, 16'd20}) begin
            n_bad++;
            $display("FAIL en_off: got %h want %h", {locked, lock_lost, period}, {1'b0, 1'b0, 16'd20});
        end
        cycles(5);
        n_cmp++;
        if (got_q.size() != 8) begin
            n_bad++;
            $display("FAIL en_off_events: got %0d events want 8", got_q.size());
        end
        en = 1'b1;
        drive(q);
        n_cmp++;
        if (got_q.size() != 16 || locked !== 1'b1) begin
            n_bad++;
            $display("FAIL en_relock: got %0d events locked %b want 16 locked 1", got_q.size(), locked);
        end
    endtask

    task automatic test_reset_async();
        iq_t q;
        start();
        q = '{20, 20, 20};
        drive(q);
        n_cmp++;
        if (period !== 16'd20) begin
            n_bad++;
            $display("FAIL acq_period: got %0d want 20", period);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({locked, period, period_valid, lock_lost} !== 19'd0) begin
            n_bad++;
            $display("FAIL async_reset: got %h want 0", {locked, period, period_valid, lock_lost});
        end
        cycles(2);
        rst = 1'b1;
    endtask

    task automatic test_random();
        iq_t  q;
        evq_t exp_q;
        int   r;
        for (int it = 0; it < 6; it++) begin
            start();
            q.delete();
            repeat ($urandom_range(10, 25)) begin
                r = $urandom_range(0, 9);
                if (r <= 5)      q.push_back($urandom_range(19, 21));
                else if (r == 6) q.push_back(18);
                else if (r == 7) q.push_back(22);
                else if (r == 8) q.push_back(20);
                else             q.push_back($urandom_range(8, 40));
            end
            drive(q);
            exp_q = model(q);
            n_cmp++;
            if (got_q.size() != exp_q.size()) begin
                n_bad++;
                $display("FAIL rand_count[%0d]: got %0d events want %0d", it, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL rand_event[%0d][%0d]: got %h want %h", it, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_mismatch_relock();
        test_tolerance_edges();
        test_timeout();
        test_coincident_timeout();
        test_enable_off();
        test_reset_async();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
